regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32×32 register file. After reset it clears all 32 registers through the single write port (the register file itself has no reset). It then shares that write port between NREQ writeback requesters, for example ALU writeback and load writeback, using round-robin arbitration and a valid/ready handshake. It drives the register file's write-enable, write-address and write-data inputs directly.

## Interface
- NREQ, 2: number of writeback requesters (2..8)
- DW, 32: data width
- AW, 5: register address width; NREGS = 2**AW = 32
- clk  in  1: single clock; all logic on rising edge
- rst_n  in  1: reset, synchronous, active-low
- req_valid  in  NREQ: per-requester write request
- req_ready  out  NREQ: per-requester accept; at most one bit high per cycle
- req_addr  in  NREQ*AW: requester i address at [i*AW +: AW]
- req_data  in  NREQ*DW: requester i data at [i*DW +: DW]
- init_done  out  1: high once the clear sweep has finished
- rf_we  out  1: register file write enable (registered)
- rf_addr  out  AW: register file write address (registered)
- rf_wd  out  DW: register file write data (registered)
- grant_id  out  $clog2(NREQ): index of the last accepted requester (registered)

## Operation
- States: CLEAR, RUN.
  - Reset forces CLEAR, clr_cnt=0, rr_ptr=NREQ-1.
  - CLEAR → RUN when clr_cnt reaches NREGS-1 and that write has been issued.
  - There is no other transition; only reset returns to CLEAR.
- CLEAR behaviour:
  - One write per cycle: rf_we=1, rf_addr=clr_cnt, rf_wd=0; clr_cnt increments.
  - req_ready=0 throughout.
- RUN arbitration:
  - Candidates are the requesters with req_valid=1.
  - Search starts at (rr_ptr+1) mod NREQ and wraps around; the first valid requester is granted.
  - req_ready[g]=1 for the granted requester only. req_ready is combinational from state, rr_ptr and req_valid.
- On acceptance (valid && ready):
  - Next cycle rf_addr=req_addr[g] and rf_wd=req_data[g].
  - rf_we=1 unless req_addr[g]==0. Writes to $0 are accepted but suppressed, which keeps $0 at zero.
  - rr_ptr and grant_id are set to g.
- No acceptance: rf_we=0 next cycle; rf_addr and rf_wd hold their previous values.
- Handshake rules:
  - A requester keeps valid, addr and data stable until it sees ready.
  - valid may drop only after acceptance.
  - Unaccepted requests are never lost.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… and no requester waits more than NREQ-1 cycles.
- Ordering: there is no reordering within a requester. Two requesters writing the same address in consecutive grants land in grant order; the last write wins.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_wd=0, init_done=0, grant_id=0, req_ready=0.
- Cycle numbering: cycle 0 is the first cycle in which rst_n samples 1.
  - Cycles 1..32: rf_we=1, rf_addr=0..31, rf_wd=0.
  - Cycle 32: init_done rises and req_ready may assert.
- Latency: acceptance in cycle t gives rf_* asserted in cycle t+1; the register file updates at the edge ending t+1.
- Throughput: one accepted write per cycle, sustained.
- Reset mid-CLEAR or mid-RUN:
  - The registered write in flight is dropped (rf_we=0 the next cycle).
  - clr_cnt restarts at 0 and the full sweep repeats.
  - Requesters must re-present their requests.
- Width rules:
  - clr_cnt is AW+1 bits so the terminal count is detected without wrap-around.
  - rr_ptr is $clog2(NREQ) bits with modulo-NREQ increment; non-power-of-two NREQ is legal.

## Structure
- Shared package regfile_pkg holds:
  - constants RF_AW=5, RF_DW=32, RF_NREGS=32, RF_ZERO_ADDR=0
  - the state enum {CLEAR, RUN}
- One sub-module, rr_arbiter (parameter NREQ):
  - inputs: req vector, rr_ptr
  - outputs: one-hot grant, grant index, any_grant
  - purely combinational
- The top level holds the FSM, clr_cnt, rr_ptr and the output registers.

## Test plan
- Reset then idle: release rst_n → rf_we high for cycles 1..32 with addresses 0..31 and data 0; init_done=1 from cycle 32; no rf_we afterwards.
- Single requester: req0 valid, addr=5, data=0xDEADBEEF at cycle 40 → ready0=1 in cycle 40; cycle 41 shows rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; grant_id=0.
- Contention, NREQ=2: both valid continuously with distinct addresses → grants alternate 0,1,0,1; each requester waits at most 1 cycle; rf_we high every cycle.
- $0 write: req1 writes addr=0, data=0xFFFFFFFF → ready1=1, then rf_we=0 next cycle; a later read of $0 returns 0.
- Held request during CLEAR: req0 valid from cycle 2 → ready0 stays 0 until cycle 32; the write appears in cycle 33 with the original addr and data.
- Reset mid-RUN: assert rst_n=0 in the cycle after an acceptance → no rf_we next cycle; after release the full 32-write clear sweep repeats.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and types shared by the register-file write-port controller.
//   RF_AW / RF_DW / RF_NREGS : register file geometry (32 x 32)
//   RF_ZERO_ADDR             : hard-wired zero register, writes to it are suppressed
//   rf_state_e               : controller state (CLEAR sweep, then RUN arbitration)
package regfile_pkg;

  localparam int RF_AW        = 5;
  localparam int RF_DW        = 32;
  localparam int RF_NREGS     = 32;
  localparam int RF_ZERO_ADDR = 0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req       in  NREQ         : request vector
//   rr_ptr    in  $clog2(NREQ) : last granted index; search starts at rr_ptr+1
//   grant     out NREQ         : one-hot grant
//   grant_idx out $clog2(NREQ) : index of the granted requester
//   any_grant out 1            : at least one request present
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_grant
);

  // Walk the requesters starting just after rr_ptr, wrapping modulo NREQ;
  // the first asserted request wins. Works for non-power-of-two NREQ.
  always_comb begin
    int cand_v;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand_v    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_v = (int'(rr_ptr) + k) % NREQ;
      if (!any_grant && req[cand_v]) begin
        any_grant     = 1'b1;
        grant[cand_v] = 1'b1;
        grant_idx     = IW'(cand_v);
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-port controller for the 32x32 register file.
// After reset it sweeps zeros into every register through the write port,
// then shares the port between NREQ writeback requesters round-robin.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is combinational)
//   req_addr / req_data   : packed per-requester address and data
//   init_done             : clear sweep finished
//   rf_we/rf_addr/rf_wd   : registered register-file write port
//   grant_id              : index of the last accepted requester
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 init_done,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_addr,
  output logic [DW-1:0]        rf_wd,
  output logic [GW-1:0]        grant_id
);

  localparam int NREGS = 2 ** AW;

  rf_state_e         state_r;
  logic [AW:0]       clr_cnt_r;   // one spare bit: terminal count never wraps
  logic [GW-1:0]     rr_ptr_r;
  logic              init_done_r;
  logic              rf_we_r;
  logic [AW-1:0]     rf_addr_r;
  logic [DW-1:0]     rf_wd_r;
  logic [GW-1:0]     grant_id_r;

  logic [NREQ-1:0]   grant_s;
  logic [GW-1:0]     grant_idx_s;
  logic              any_grant_s;
  logic              accept_s;
  logic [AW-1:0]     sel_addr_s;
  logic [DW-1:0]     sel_data_s;

  rr_arbiter #(.NREQ(NREQ), .IW(GW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (any_grant_s)
  );

  // Ready is only offered once the sweep is done, so nothing is lost during CLEAR.
  assign req_ready  = (state_r == RUN) ? grant_s : '0;
  assign accept_s   = (state_r == RUN) && any_grant_s;
  assign sel_addr_s = req_addr[int'(grant_idx_s)*AW +: AW];
  assign sel_data_s = req_data[int'(grant_idx_s)*DW +: DW];

  // Controller FSM, sweep counter, round-robin pointer and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= '0;
      rr_ptr_r    <= GW'(NREQ - 1);
      init_done_r <= 1'b0;
      rf_we_r     <= 1'b0;
      rf_addr_r   <= '0;
      rf_wd_r     <= '0;
      grant_id_r  <= '0;
    end else begin
      case (state_r)
        CLEAR: begin
          rf_we_r   <= 1'b1;
          rf_addr_r <= clr_cnt_r[AW-1:0];
          rf_wd_r   <= '0;
          clr_cnt_r <= clr_cnt_r + (AW+1)'(1);
          if (clr_cnt_r == (AW+1)'(NREGS - 1)) begin
            state_r     <= RUN;
            init_done_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
          end
        end
        RUN: begin
          if (accept_s) begin
            // Writes to the zero register are accepted but never reach the file.
            rf_we_r    <= (sel_addr_s != AW'(RF_ZERO_ADDR));
            rf_addr_r  <= sel_addr_s;
            rf_wd_r    <= sel_data_s;
            rr_ptr_r   <= grant_idx_s;
            grant_id_r <= grant_idx_s;
          end else begin
            rf_we_r <= 1'b0;
          end
        end
        default: begin
          state_r <= CLEAR;
        end
      endcase
    end
  end

  assign init_done = init_done_r;
  assign rf_we     = rf_we_r;
  assign rf_addr   = rf_addr_r;
  assign rf_wd     = rf_wd_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter (NREQ=2): directed vectors plus hand
// sequences for the clear sweep, contention, held requests and reset mid-RUN.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        init_done;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic [0:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mem [0:31];

  regfile_wb_arbiter #(.NREQ(2), .DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .init_done (init_done),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wd     (rf_wd),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model written by the DUT's write port.
  always @(posedge clk) begin
    if (rf_we === 1'b1) mem[rf_addr] <= rf_wd;
  end

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        gid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  // Hold reset a few cycles, release it; returns in cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // From cycle 0 through cycle 32; optional held req0 from cycle 2.
  task automatic do_sweep(input bit hold);
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_addr", rf_addr, 5'd0);
    chk("rst_rf_wd", rf_wd, 32'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (hold && c == 2) drive(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0);
      #1;
      chk("clr_rf_we", rf_we, 1'b1);
      chk("clr_rf_addr", rf_addr, 64'(c - 1));
      chk("clr_rf_wd", rf_wd, 32'h0);
      chk("clr_init_done", init_done, (c == 32) ? 1'b1 : 1'b0);
      chk("clr_req_ready", req_ready, (hold && c == 32) ? 2'b01 : 2'b00);
    end
  endtask

  initial begin
    logic [4:0] n0, n1, pa;
    logic [31:0] pd;
    logic exp_g, prev_g;

    vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{2'b11, 5'd6, 32'h11111111, 5'd7, 32'h22222222, 2'b10, 1'b1, 5'd7, 32'h22222222, 1'b1};
    vecs[2] = '{2'b11, 5'd6, 32'h11111111, 5'd8, 32'h33333333, 2'b01, 1'b1, 5'd6, 32'h11111111, 1'b0};
    vecs[3] = '{2'b11, 5'd9, 32'h44444444, 5'd8, 32'h33333333, 2'b10, 1'b1, 5'd8, 32'h33333333, 1'b1};
    vecs[4] = '{2'b11, 5'd9, 32'h44444444, 5'd0, 32'hFFFFFFFF, 2'b01, 1'b1, 5'd9, 32'h44444444, 1'b0};
    vecs[5] = '{2'b10, 5'd0, 32'h0,        5'd0, 32'hFFFFFFFF, 2'b10, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{2'b10, 5'd0, 32'h0,        5'd5, 32'hCAFEF00D, 2'b10, 1'b1, 5'd5, 32'hCAFEF00D, 1'b1};
    vecs[8] = '{2'b01, 5'd5, 32'h0BADC0DE, 5'd0, 32'h0,        2'b01, 1'b1, 5'd5, 32'h0BADC0DE, 1'b0};
    vecs[9] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 1'b0, 5'd5, 32'h0BADC0DE, 1'b0};

    // Reset, clear sweep, then idle up to cycle 40.
    do_reset();
    do_sweep(1'b0);
    for (int c = 33; c <= 40; c++) begin
      tick();
      #1;
      chk("idle_rf_we", rf_we, 1'b0);
      chk("idle_req_ready", req_ready, 2'b00);
    end
    chk("mem_cleared_31", mem[31], 32'h0);

    // Directed vectors starting at cycle 40.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].ready);
      tick();
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].we);
      chk($sformatf("v%0d_rf_addr", i), rf_addr, vecs[i].addr);
      chk($sformatf("v%0d_rf_wd", i), rf_wd, vecs[i].wd);
      chk($sformatf("v%0d_grant_id", i), grant_id, vecs[i].gid);
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("mem_zero_reg", mem[0], 32'h0);
    chk("mem_last_write_wins", mem[5], 32'h0BADC0DE);
    chk("mem_6", mem[6], 32'h11111111);
    chk("mem_7", mem[7], 32'h22222222);
    chk("mem_9", mem[9], 32'h44444444);

    // Contention: both always valid; last grant was 0, so 1,0,1,0,...
    n0 = 5'd0; n1 = 5'd0; pa = 5'd0; pd = 32'h0; prev_g = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 1'b1 : 1'b0;
      drive(2'b11, 5'd10 + n0, 32'h10000000 + 32'(n0), 5'd20 + n1, 32'h20000000 + 32'(n1));
      #1;
      chk("cont_req_ready", req_ready, exp_g ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("cont_rf_we", rf_we, 1'b1);
        chk("cont_rf_addr", rf_addr, pa);
        chk("cont_rf_wd", rf_wd, pd);
        chk("cont_grant_id", grant_id, prev_g);
      end
      if (exp_g) begin
        pa = 5'd20 + n1; pd = 32'h20000000 + 32'(n1); n1 = n1 + 5'd1;
      end else begin
        pa = 5'd10 + n0; pd = 32'h10000000 + 32'(n0); n0 = n0 + 5'd1;
      end
      prev_g = exp_g;
      tick();
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("cont_last_addr", rf_addr, pa);
    chk("cont_last_wd", rf_wd, pd);
    chk("cont_last_gid", grant_id, prev_g);

    // Reset in the cycle after an acceptance drops the in-flight write.
    drive(2'b01, 5'd12, 32'h12121212, 5'd0, 32'h0);
    #1;
    chk("midrun_req_ready", req_ready, 2'b01);
    tick();
    rst_n = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("midrun_inflight_we", rf_we, 1'b1);
    chk("midrun_inflight_addr", rf_addr, 5'd12);
    tick();
    chk("midrun_dropped_we", rf_we, 1'b0);
    chk("midrun_init_done", init_done, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;
    do_sweep(1'b0);

    // Request held across the clear sweep is served right after it.
    do_reset();
    do_sweep(1'b1);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("hold_rf_we", rf_we, 1'b1);
    chk("hold_rf_addr", rf_addr, 5'd3);
    chk("hold_rf_wd", rf_wd, 32'hA5A5A5A5);
    chk("hold_grant_id", grant_id, 1'b0);
    tick();
    chk("hold_after_we", rf_we, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
